// File: rtl/dmg_pkg.sv
// ---------------------------------------------------------------------------
// dmg_pkg
// Shared definitions for the reduced SM83 (DMG) CPU:
//   - register-file index constants (B..PCL)
//   - flag bit positions inside the flags register
//   - FSM state and ALU operation enums
//   - opcode constants and small decode/ALU helper functions
// Optional build macro used by the design: DMG_TRACE_EN (see dmg_cpu.sv).
// ---------------------------------------------------------------------------
package dmg_pkg;

  // Register file indices (16 x 8; indices 6, 14, 15 unused)
  localparam logic [3:0] RF_B   = 4'd0;
  localparam logic [3:0] RF_C   = 4'd1;
  localparam logic [3:0] RF_D   = 4'd2;
  localparam logic [3:0] RF_E   = 4'd3;
  localparam logic [3:0] RF_H   = 4'd4;
  localparam logic [3:0] RF_L   = 4'd5;
  localparam logic [3:0] RF_A   = 4'd7;
  localparam logic [3:0] RF_Z   = 4'd8;
  localparam logic [3:0] RF_W   = 4'd9;
  localparam logic [3:0] RF_SPH = 4'd10;
  localparam logic [3:0] RF_SPL = 4'd11;
  localparam logic [3:0] RF_PCH = 4'd12;
  localparam logic [3:0] RF_PCL = 4'd13;

  // Flag bit positions; bits 3:0 always read as zero
  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  typedef enum logic [2:0] {
    ST_FETCH0 = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_IMM0   = 3'd2,
    ST_IMM1   = 3'd3,
    ST_IMM2   = 3'd4,
    ST_IMM3   = 3'd5,
    ST_EXEC   = 3'd6,
    ST_HALTED = 3'd7
  } state_e;

  // Encoding matches opcode bits [5:3] of the 10ooosss group
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_OR  = 3'd6,
    ALU_CP  = 3'd7
  } alu_op_e;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_JP   = 8'hC3;
  localparam logic [7:0] OP_JR   = 8'h18;
  localparam logic [7:0] OP_HALT = 8'h76;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] flags;
    logic       wr;     // 0 for CP: result is discarded
  } alu_res_t;

  // LD r,d8 : 00rrr110 with r != 6
  function automatic logic is_ld_r_d8(input logic [7:0] op);
    return (op[7:6] == 2'b00) && (op[2:0] == 3'b110) && (op[5:3] != 3'd6);
  endfunction

  // LD rr,d16 : 00rr0001
  function automatic logic is_ld_rr_d16(input logic [7:0] op);
    return (op[7:6] == 2'b00) && (op[3:0] == 4'b0001);
  endfunction

  // Opcodes that fetch at least one immediate byte
  function automatic logic needs_imm(input logic [7:0] op);
    return is_ld_r_d8(op) || is_ld_rr_d16(op) || (op == OP_JP) || (op == OP_JR);
  endfunction

  // High register of the rr pair; the low register is always the next index
  function automatic logic [3:0] rr_hi_idx(input logic [7:0] op);
    logic [3:0] idx;
    case (op[5:4])
      2'd0:    idx = RF_B;
      2'd1:    idx = RF_D;
      2'd2:    idx = RF_H;
      2'd3:    idx = RF_SPH;
      default: idx = RF_B;
    endcase
    return idx;
  endfunction

  // 8-bit ALU with SM83 flag rules. 9-bit/5-bit arithmetic makes bit 8 the
  // carry/borrow and bit 4 the half-carry/half-borrow for both add and sub.
  function automatic alu_res_t alu_exec(input alu_op_e op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    alu_res_t   r;
    logic [8:0] full;
    logic [4:0] half;
    logic       n;
    r    = '0;
    full = 9'd0;
    half = 5'd0;
    n    = 1'b0;
    case (op)
      ALU_ADD: begin
        full = {1'b0, a} + {1'b0, b};
        half = {1'b0, a[3:0]} + {1'b0, b[3:0]};
      end
      ALU_ADC: begin
        full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        half = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
      end
      ALU_SUB, ALU_CP: begin
        full = {1'b0, a} - {1'b0, b};
        half = {1'b0, a[3:0]} - {1'b0, b[3:0]};
        n    = 1'b1;
      end
      ALU_SBC: begin
        full = {1'b0, a} - {1'b0, b} - {8'd0, cin};
        half = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, cin};
        n    = 1'b1;
      end
      ALU_AND: begin
        full = {1'b0, a & b};
        half = 5'b10000;          // AND always sets H
      end
      ALU_XOR: full = {1'b0, a ^ b};
      ALU_OR:  full = {1'b0, a | b};
      default: full = {1'b0, a};
    endcase
    r.res   = full[7:0];
    r.wr    = (op != ALU_CP);
    r.flags = {(full[7:0] == 8'h00), n, half[4], full[8], 4'b0000};
    return r;
  endfunction

endpackage

// File: rtl/dmg_cpu.sv
// ---------------------------------------------------------------------------
// dmg_cpu
// Reduced SM83 CPU core: register file `rf`, `flags`, fetch/execute FSM and
// ALU. Fetches opcodes and immediates from a 1-cycle registered ROM.
// Ports:
//   clk_i       system clock, posedge
//   rst_ni      asynchronous active-low reset
//   rom_addr_o  ROM byte address, combinational PC[14:0]
//   rom_data_i  ROM data, valid one clock after the address
// Build macro: DMG_TRACE_EN -- when defined, prints a trace line at every
// instruction retire (simulation only). Undefined: no trace logic.
// ---------------------------------------------------------------------------
module dmg_cpu
  import dmg_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'hFFFE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [14:0] rom_addr_o,
  input  logic [7:0]  rom_data_i
);

  logic [7:0] rf   [16];
  logic [7:0] rf_d [16];
  logic [7:0] flags;
  logic [7:0] flags_d;
  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;

  logic [15:0] pc_s;
  logic [15:0] pc_inc_s;
  logic [15:0] jr_tgt_s;
  logic [7:0]  incdec_src_s;
  logic [7:0]  inc_res_s;
  logic [7:0]  dec_res_s;
  logic [2:0]  op_dst_s;
  logic [2:0]  op_src_s;
  alu_res_t    alu_s;

  assign pc_s       = {rf[RF_PCH], rf[RF_PCL]};
  assign pc_inc_s   = pc_s + 16'd1;                  // natural 16-bit wrap
  assign jr_tgt_s   = pc_s + {{8{rf[RF_Z][7]}}, rf[RF_Z]};
  assign rom_addr_o = pc_s[14:0];

  // Single-byte instructions execute straight from rom_data_i in FETCH1
  assign op_dst_s     = rom_data_i[5:3];
  assign op_src_s     = rom_data_i[2:0];
  assign incdec_src_s = rf[{1'b0, op_dst_s}];
  assign inc_res_s    = incdec_src_s + 8'd1;
  assign dec_res_s    = incdec_src_s - 8'd1;
  assign alu_s        = alu_exec(alu_op_e'(op_dst_s), rf[RF_A], rf[{1'b0, op_src_s}],
                                 flags[FLAG_C]);

  // State, register file and flags registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) begin
        rf[i] <= 8'h00;
      end
      rf[RF_SPH] <= RESET_SP[15:8];
      rf[RF_SPL] <= RESET_SP[7:0];
      rf[RF_PCH] <= RESET_PC[15:8];
      rf[RF_PCL] <= RESET_PC[7:0];
      flags      <= 8'h00;
      state_q    <= ST_FETCH0;
      ir_q       <= 8'h00;
    end else begin
      rf      <= rf_d;
      flags   <= flags_d;
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, operand capture and execute logic
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flags_d = flags;
    rf_d    = rf;
    case (state_q)
      ST_FETCH0: state_d = ST_FETCH1;

      ST_FETCH1: begin
        ir_d         = rom_data_i;
        rf_d[RF_PCH] = pc_inc_s[15:8];
        rf_d[RF_PCL] = pc_inc_s[7:0];
        if (rom_data_i == OP_HALT) begin
          state_d = ST_HALTED;
        end else if (needs_imm(rom_data_i)) begin
          state_d = ST_IMM0;
        end else begin
          state_d = ST_FETCH0;
          if ((rom_data_i[7:6] == 2'b00) && (rom_data_i[2:1] == 2'b10) &&
              (op_dst_s != 3'd6)) begin
            // INC r (bit0=0) / DEC r (bit0=1); carry is preserved
            if (!rom_data_i[0]) begin
              rf_d[{1'b0, op_dst_s}] = inc_res_s;
              flags_d = {(inc_res_s == 8'h00), 1'b0, (incdec_src_s[3:0] == 4'hF),
                         flags[FLAG_C], 4'b0000};
            end else begin
              rf_d[{1'b0, op_dst_s}] = dec_res_s;
              flags_d = {(dec_res_s == 8'h00), 1'b1, (incdec_src_s[3:0] == 4'h0),
                         flags[FLAG_C], 4'b0000};
            end
          end else if ((rom_data_i[7:6] == 2'b01) && (op_dst_s != 3'd6) &&
                       (op_src_s != 3'd6)) begin
            rf_d[{1'b0, op_dst_s}] = rf[{1'b0, op_src_s}];
          end else if ((rom_data_i[7:6] == 2'b10) && (op_src_s != 3'd6)) begin
            if (alu_s.wr) begin
              rf_d[RF_A] = alu_s.res;
            end else begin
              rf_d[RF_A] = rf[RF_A];
            end
            flags_d = alu_s.flags;
          end else begin
            // Unsupported opcode or (HL) operand: behaves as NOP
            flags_d = flags;
          end
        end
      end

      ST_IMM0: state_d = ST_IMM1;

      ST_IMM1: begin
        rf_d[RF_Z]   = rom_data_i;
        rf_d[RF_PCH] = pc_inc_s[15:8];
        rf_d[RF_PCL] = pc_inc_s[7:0];
        if (is_ld_r_d8(ir_q)) begin
          rf_d[{1'b0, ir_q[5:3]}] = rom_data_i;
          state_d = ST_FETCH0;
        end else if (ir_q == OP_JR) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IMM2;
        end
      end

      ST_IMM2: state_d = ST_IMM3;

      ST_IMM3: begin
        rf_d[RF_W]   = rom_data_i;
        rf_d[RF_PCH] = pc_inc_s[15:8];
        rf_d[RF_PCL] = pc_inc_s[7:0];
        state_d      = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH0;
        if (ir_q == OP_JP) begin
          rf_d[RF_PCH] = rf[RF_W];
          rf_d[RF_PCL] = rf[RF_Z];
        end else if (ir_q == OP_JR) begin
          rf_d[RF_PCH] = jr_tgt_s[15:8];
          rf_d[RF_PCL] = jr_tgt_s[7:0];
        end else if (is_ld_rr_d16(ir_q)) begin
          rf_d[rr_hi_idx(ir_q)]         = rf[RF_W];
          rf_d[rr_hi_idx(ir_q) + 4'd1]  = rf[RF_Z];
        end else begin
          rf_d[RF_A] = rf[RF_A];
        end
      end

      ST_HALTED: state_d = ST_HALTED;   // left only through reset

      default: state_d = ST_FETCH0;
    endcase
  end

`ifdef DMG_TRACE_EN
  logic [15:0] op_pc_q;
  logic        retire_s;
  logic [7:0]  retire_op_s;
  logic [15:0] retire_pc_s;

  // An instruction retires on any return to FETCH0 or on entry to HALTED
  assign retire_s    = ((state_q != ST_FETCH0) && (state_d == ST_FETCH0)) ||
                       ((state_q == ST_FETCH1) && (state_d == ST_HALTED));
  assign retire_op_s = (state_q == ST_FETCH1) ? rom_data_i : ir_q;
  assign retire_pc_s = (state_q == ST_FETCH1) ? pc_s : op_pc_q;

  // Address of the opcode currently in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_pc_q <= RESET_PC;
    end else if (state_q == ST_FETCH1) begin
      op_pc_q <= pc_s;
    end else begin
      op_pc_q <= op_pc_q;
    end
  end

  // Retire trace with architectural state after the instruction
  always_ff @(posedge clk_i) begin
    if (rst_ni && retire_s) begin
      $display("TRACE pc=%04h op=%02h AF=%02h%02h BC=%02h%02h DE=%02h%02h HL=%02h%02h SP=%02h%02h",
               retire_pc_s, retire_op_s, rf_d[RF_A], flags_d, rf_d[RF_B], rf_d[RF_C],
               rf_d[RF_D], rf_d[RF_E], rf_d[RF_H], rf_d[RF_L], rf_d[RF_SPH], rf_d[RF_SPL]);
    end
  end
`endif

endmodule

// File: rtl/dmg_main_core.sv
// ---------------------------------------------------------------------------
// dmg_main_core
// Top of the minimal DMG datapath: wraps the reduced SM83 CPU (instance
// `cpu`) and exposes the external cartridge ROM interface.
// Ports:
//   clk       system clock, posedge
//   rst       asynchronous active-low reset
//   rom_addr  ROM byte address (combinational PC[14:0])
//   rom_data  ROM read data, valid one clock after the address
// Build macro: DMG_TRACE_EN enables the retire trace inside `cpu`.
// ---------------------------------------------------------------------------
module dmg_main_core
  import dmg_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data
);

  dmg_cpu #(
    .RESET_PC (RESET_PC),
    .RESET_SP (RESET_SP)
  ) cpu (
    .clk_i      (clk),
    .rst_ni     (rst),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data)
  );

endmodule

// File: tb/tb_dmg_main_core.sv
module tb_dmg_main_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  rom [32768];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Synchronous cartridge ROM: data appears one clock after the address
  always @(posedge clk) rom_data <= rom[rom_addr];

  dmg_main_core #(.RESET_PC(16'h0000), .RESET_SP(16'hFFFE)) dut (
    .clk      (clk),
    .rst      (rst),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  typedef struct {
    string       name;
    logic [63:0] prg;     // bytes from address 0000, first byte in [63:56]
    logic [15:0] hi;      // bytes at 0010/0011
    int          ncyc;
    logic [7:0]  exp_a;
    logic [7:0]  exp_f;
    logic [7:0]  exp_b;
    logic [15:0] exp_pc;
    logic [15:0] exp_sp;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic load(input logic [63:0] prg, input logic [15:0] hi);
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    for (int i = 0; i < 8; i++) rom[i] = prg[63 - 8*i -: 8];
    rom[16] = hi[15:8];
    rom[17] = hi[7:0];
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [15:0] get_pc();
    return {dut.cpu.rf[12], dut.cpu.rf[13]};
  endfunction

  function automatic logic [15:0] get_sp();
    return {dut.cpu.rf[10], dut.cpu.rf[11]};
  endfunction

  initial begin
    //          name            program                  hi        clk  A      F      B      PC        SP
    vecs[0]  = '{"ld_add",     64'h3E12_0634_8000_0000, 16'h0000, 10, 8'h46, 8'h00, 8'h34, 16'h0005, 16'hFFFE};
    vecs[1]  = '{"inc_wrap",   64'h3EFF_3C00_0000_0000, 16'h0000,  6, 8'h00, 8'hA0, 8'h00, 16'h0003, 16'hFFFE};
    vecs[2]  = '{"and_d8_nop", 64'h3E0F_E6F0_0000_0000, 16'h0000,  8, 8'h0F, 8'h00, 8'h00, 16'h0004, 16'hFFFE};
    vecs[3]  = '{"and_b",      64'h3E0F_06F0_A000_0000, 16'h0000, 10, 8'h00, 8'hA0, 8'hF0, 16'h0005, 16'hFFFE};
    vecs[4]  = '{"ld_sp_jp",   64'h31FE_CFC3_1000_0000, 16'h0000, 14, 8'h00, 8'h00, 8'h00, 16'h0010, 16'hCFFE};
    vecs[5]  = '{"jr_loop",    64'h31FE_CFC3_1000_0000, 16'h18FE, 29, 8'h00, 8'h00, 8'h00, 16'h0010, 16'hCFFE};
    vecs[6]  = '{"sub_b",      64'h3E10_0601_9000_0000, 16'h0000, 10, 8'h0F, 8'h60, 8'h01, 16'h0005, 16'hFFFE};
    vecs[7]  = '{"dec_wrap",   64'h3E00_3D00_0000_0000, 16'h0000,  6, 8'hFF, 8'h60, 8'h00, 16'h0003, 16'hFFFE};
    vecs[8]  = '{"add_adc",    64'h3EF0_0620_8088_0000, 16'h0000, 12, 8'h31, 8'h00, 8'h20, 16'h0006, 16'hFFFE};
    vecs[9]  = '{"cp_b",       64'h3E05_0605_B800_0000, 16'h0000, 10, 8'h05, 8'hC0, 8'h05, 16'h0005, 16'hFFFE};
    vecs[10] = '{"xor_b",      64'h3E5A_06FF_A800_0000, 16'h0000, 10, 8'hA5, 8'h00, 8'hFF, 16'h0005, 16'hFFFE};
    vecs[11] = '{"or_a",       64'h3E00_B700_0000_0000, 16'h0000,  6, 8'h00, 8'h80, 8'h00, 16'h0003, 16'hFFFE};
    vecs[12] = '{"sbc_b",      64'h3EFF_0601_8098_0000, 16'h0000, 12, 8'hFE, 8'h70, 8'h01, 16'h0006, 16'hFFFE};
    vecs[13] = '{"ld_rr_hl",   64'h3E77_477E_0000_0000, 16'h0000,  8, 8'h77, 8'h00, 8'h77, 16'h0004, 16'hFFFE};
    vecs[14] = '{"ld_bc_d16",  64'h0134_1200_0000_0000, 16'h0000,  7, 8'h00, 8'h00, 8'h12, 16'h0003, 16'hFFFE};

    // Reset state while rst is held low
    load(64'h0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.rom_addr", {1'b0, rom_addr}, 16'h0000);
    check("rst.sp", get_sp(), 16'hFFFE);
    check("rst.af", {dut.cpu.rf[7], dut.cpu.flags}, 16'h0000);

    // First opcode is sampled at the 2nd edge after release
    rom[0] = 8'h3C;   // INC A
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("first.pc_1clk", get_pc(), 16'h0000);
    check("first.a_1clk", {8'h00, dut.cpu.rf[7]}, 16'h0000);
    @(posedge clk); @(negedge clk);
    check("first.pc_2clk", get_pc(), 16'h0001);
    check("first.a_2clk", {8'h00, dut.cpu.rf[7]}, 16'h0001);

    // Table of directed programs
    for (int v = 0; v < 15; v++) begin
      rst = 1'b0;
      load(vecs[v].prg, vecs[v].hi);
      release_reset();
      repeat (vecs[v].ncyc) @(posedge clk);
      @(negedge clk);
      check({vecs[v].name, ".A"},  {8'h00, dut.cpu.rf[7]}, {8'h00, vecs[v].exp_a});
      check({vecs[v].name, ".F"},  {8'h00, dut.cpu.flags}, {8'h00, vecs[v].exp_f});
      check({vecs[v].name, ".B"},  {8'h00, dut.cpu.rf[0]}, {8'h00, vecs[v].exp_b});
      check({vecs[v].name, ".PC"}, get_pc(), vecs[v].exp_pc);
      check({vecs[v].name, ".SP"}, get_sp(), vecs[v].exp_sp);
    end

    // HALT freezes PC/rom_addr; the following INC A never runs
    rst = 1'b0;
    load(64'h763C_0000_0000_0000, 16'h0000);
    release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("halt.pc_entry", get_pc(), 16'h0001);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("halt.pc_100", get_pc(), 16'h0001);
    check("halt.rom_addr", {1'b0, rom_addr}, 16'h0001);
    check("halt.a", {8'h00, dut.cpu.rf[7]}, 16'h0000);

    // Asynchronous reset in the middle of LD A,d8 discards the write
    rst = 1'b0;
    load(64'h3E12_3C00_0000_0000, 16'h0000);
    release_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort.pc_mid", get_pc(), 16'h0001);
    rst = 1'b0;
    #1;
    check("abort.pc_async", get_pc(), 16'h0000);
    check("abort.rom_addr", {1'b0, rom_addr}, 16'h0000);
    check("abort.a", {8'h00, dut.cpu.rf[7]}, 16'h0000);
    @(posedge clk);
    #1;
    check("abort.a_held", {8'h00, dut.cpu.rf[7]}, 16'h0000);
    release_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort.rerun_a", {8'h00, dut.cpu.rf[7]}, 16'h0012);
    check("abort.rerun_pc", get_pc(), 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
